// File: rtl/mux_feeder.sv
// ----------------------------------------------------------------------------
// mux_feeder
//
// Registered front-end for the 4-to-2 mux stage. Accepts 4-bit words over a
// Load/Ready handshake and presents each one on W. While a word is shown,
// sel steps 0 -> 1 and stays on each value for HOLD cycles, so the mux
// output carries W[1:0] and then W[3:2]. A one-word pending buffer lets the
// next word be taken while the current one is still on the outputs.
//
// State table
//   state | meaning
//   IDLE  | nothing presented, Valid=0, pending buffer empty
//   LOW   | presenting W[1:0] (sel=0)
//   HIGH  | presenting W[3:2] (sel=1); final cycle pulses Done next cycle
//
// Ports
//   Clock   in   system clock, rising edge
//   Resetn  in   asynchronous active-low reset
//   D       in   [3:0] word offered by the source
//   Load    in   request; accepted on a rising edge with Ready=1
//   Ready   out  1 while the pending buffer is empty
//   W       out  [3:0] word under presentation (to mux W)
//   sel     out  half select (to mux sel), 0 = W[1:0], 1 = W[3:2]
//   Valid   out  1 while W/sel carry a half being presented
//   Done    out  one-cycle pulse after the high half of a word completes
//
// HOLD: cycles per half, legal range 1..255.
// ----------------------------------------------------------------------------
module mux_feeder #(
    parameter int HOLD = 1
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [3:0] D,
    input  logic       Load,
    output logic       Ready,
    output logic [3:0] W,
    output logic       sel,
    output logic       Valid,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(HOLD - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] pend_buf, pend_nxt;
    logic [3:0] w_nxt;
    logic       full, full_nxt;
    logic       sel_nxt, valid_nxt, done_nxt;
    logic       accept;
    logic       cnt_zero;

    assign Ready    = ~full;
    assign accept   = Load & ~full;
    assign cnt_zero = (cnt == 8'd0);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            pend_buf <= 4'd0;
            full     <= 1'b0;
            W        <= 4'd0;
            sel      <= 1'b0;
            Valid    <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pend_buf <= pend_nxt;
            full     <= full_nxt;
            W        <= w_nxt;
            sel      <= sel_nxt;
            Valid    <= valid_nxt;
            Done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend_buf;
        full_nxt  = full;
        w_nxt     = W;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    w_nxt     = D;
                    state_nxt = LOW;
                    cnt_nxt   = CNT_LOAD;
                end
            end

            LOW: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    state_nxt = HIGH;
                    cnt_nxt   = CNT_LOAD;
                end
                if (accept) begin
                    pend_nxt = D;
                    full_nxt = 1'b1;
                end
            end

            HIGH: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt - 8'd1;
                    if (accept) begin
                        pend_nxt = D;
                        full_nxt = 1'b1;
                    end
                end else begin
                    done_nxt = 1'b1;
                    // A buffered word has priority; accept is impossible
                    // while full, so the pass-through branch is exclusive.
                    if (full) begin
                        w_nxt     = pend_buf;
                        full_nxt  = 1'b0;
                        state_nxt = LOW;
                        cnt_nxt   = CNT_LOAD;
                    end else if (accept) begin
                        w_nxt     = D;
                        state_nxt = LOW;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // sel and Valid are registered copies of where the FSM is going.
        sel_nxt   = (state_nxt == HIGH);
        valid_nxt = (state_nxt != IDLE);
    end

endmodule
